mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2: fixed cycles from grant to memory read data/ack; legal range 1..15.
REQ-002 Parameter STARVE_MAX, default 4: consecutive data grants tolerated while fetch waits (used only under REQ-026).
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Ports if_req in 1 (fetch request), if_addr in 32 (fetch byte address), if_gnt out 1 (fetch accepted this cycle).
REQ-006 Ports if_rvalid out 1 and if_rdata out 32: one-cycle fetch response pulse with instruction word.
REQ-007 Ports d_req in 1, d_we in 1 (1 = store), d_be in 4 (byte enables), d_addr in 32, d_wdata in 32, d_gnt out 1: data-stage request.
REQ-008 Ports d_rvalid out 1 and d_rdata out 32: load data, or store ack with d_rdata = 0.
REQ-009 Port flush, input, 1: pipeline flush; cancels the in-flight or same-cycle fetch.
REQ-010 Ports mem_en out 1, mem_we out 1, mem_be out 4, mem_addr out 32, mem_wdata out 32, mem_rdata in 32: single-port, non-pipelined memory.
REQ-011 Port busy, output, 1: high while an access is outstanding.

Function
REQ-012 FSM states IDLE, BUSY_IF, BUSY_D; 4-bit latency counter.
REQ-013 Arbitration is legal in IDLE, or in the completion cycle of BUSY_x (counter = 0), enabling back-to-back accesses.
REQ-014 Priority: d_req over if_req (modified only by REQ-026).
REQ-015 Grant cycle: gnt asserted combinationally; mem_en = 1; mem_we/mem_be/mem_addr/mem_wdata driven from the winner; fetch drives mem_we = 0, mem_be = 4'b1111.
REQ-016 On grant: state <= BUSY_IF or BUSY_D; counter <= MEM_LAT-1.
REQ-017 In BUSY_x the counter decrements each cycle; at 0 the completion cycle pulses rvalid for the owner with rdata = mem_rdata (store: d_rdata = 0).
REQ-018 Completion with no new grant: state <= IDLE; with a new grant: REQ-016 applies.
REQ-019 Throughput: one access per MEM_LAT cycles; grant at T -> rvalid at T+MEM_LAT.
REQ-020 mem_en = 0 and all mem_* outputs are 0 in every non-grant cycle.
REQ-021 flush while BUSY_IF (including the completion cycle) or in an if_gnt cycle sets a drop flag; the matching completion keeps if_rvalid = 0 and if_rdata = 0; the memory timing is unchanged.
REQ-022 flush has no effect on data accesses.
REQ-023 A requester holds req and its payload stable until gnt; a req drop before gnt withdraws the request without error.
REQ-024 busy = (state != IDLE).

Reset
REQ-025 reset in any cycle, including mid-access, forces within that edge: state IDLE, counter 0, drop flag 0, starve counter 0; all outputs 0 while reset is high, including combinational gnt/mem_*; the outstanding response is discarded and never pulses rvalid.

Configuration
REQ-026 Macro ARB_STARVE_GUARD_EN defined: a 4-bit starve counter increments on each d_gnt issued while if_req = 1, and clears on if_gnt or if_req = 0. When the count equals STARVE_MAX, the next arbitration with if_req = 1 grants fetch even if d_req = 1.
REQ-027 Macro undefined: strict data priority, no starve counter logic.

Verification (MEM_LAT = 2, STARVE_MAX = 4)
REQ-028 Fetch only: if_req = 1, if_addr = 0x10, mem_rdata = 0x00100093 -> if_gnt at T, mem_addr = 0x10 at T, if_rvalid = 1 with if_rdata = 0x00100093 at T+2, busy = 1 at T+1..T+2.
REQ-029 Simultaneous if_req (0x20) and d_req load (0x10) -> d_gnt at T, d_rvalid at T+2 coinciding with if_gnt at T+2, if_rvalid at T+4.
REQ-030 Store d_we = 1, d_be = 4'b1111, d_addr = 0x10, d_wdata = 42 -> mem_we = 1, mem_wdata = 42 at T, d_rvalid = 1 with d_rdata = 0 at T+2.
REQ-031 Fetch granted at T, flush = 1 at T+1 -> if_rvalid = 0 at T+2; d_req at T+2 granted at T+2.
REQ-032 Fetch granted at T, reset = 1 at T+1 -> all outputs 0, no if_rvalid at T+2, busy = 0 at T+2.
REQ-033 if_req and d_req held high continuously -> with ARB_STARVE_GUARD_EN grants are D,D,D,D,IF repeating; without it if_gnt never asserts.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the request/response handshakes of the fetch and data stages and
//   the single-port memory bus served by mem_port_arbiter.
//   modport slave  : the arbiter side (takes requests, drives grants/responses
//                    and the memory command bus, samples mem_rdata)
//   modport master : the requester/memory side (the opposite directions)
//   Signals:
//     if_req/if_addr/if_gnt/if_rvalid/if_rdata           fetch port
//     d_req/d_we/d_be/d_addr/d_wdata/d_gnt/d_rvalid/d_rdata data port
//     mem_en/mem_we/mem_be/mem_addr/mem_wdata/mem_rdata     memory port
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, non-pipelined memory between an instruction fetch
//   port and a data (load/store) port. Data has priority. Each access occupies
//   the memory for MEM_LAT cycles; a new grant may be issued in the
//   completion cycle of the previous access, giving back-to-back throughput.
//   A flush cancels an in-flight or same-cycle fetch: the memory access still
//   runs to completion but its response is suppressed.
//
//   Parameters:
//     MEM_LAT    (1..15) cycles from grant to response
//     STARVE_MAX consecutive data grants tolerated while fetch waits
//   Optional build macro:
//     ARB_STARVE_GUARD_EN  forces a fetch grant after STARVE_MAX data grants
//                          issued while fetch was waiting
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high; all outputs forced to 0 while high
//     flush  pipeline flush (affects fetch only)
//     busy   an access is outstanding
//     bus    mem_port_arbiter_if.slave (fetch, data and memory ports)
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  output logic               busy,
  mem_port_arbiter_if.slave  bus
);

  if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX > 15) begin : g_bad_param
    $error("mem_port_arbiter: MEM_LAT must be 1..15 and STARVE_MAX at most 15");
  end

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_D
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       drop_q, drop_d;    // outstanding fetch was flushed
  logic       store_q, store_d;  // outstanding data access is a store

  logic can_arb;
  logic complete;
  logic force_if;
  logic d_win;
  logic i_win;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_q, starve_d;

  always_comb begin
    force_if = bus.if_req && (starve_q == 4'(STARVE_MAX));
    starve_d = starve_q;
    if (i_win || !bus.if_req) begin
      starve_d = '0;
    end else if (d_win && starve_q != '1) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  always_comb begin
    force_if = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      store_q <= store_d;
    end
  end

  always_comb begin
    // The counter rests at 0 in IDLE, so "counter == 0" covers both IDLE and
    // the completion cycle of a busy state.
    can_arb  = (cnt_q == '0);
    complete = (state_q != IDLE) && (cnt_q == '0);
    d_win    = !reset && can_arb && bus.d_req && !force_if;
    i_win    = !reset && can_arb && bus.if_req && !d_win;

    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    store_d = store_q;

    bus.if_gnt    = i_win;
    bus.d_gnt     = d_win;
    bus.mem_en    = d_win || i_win;
    bus.mem_we    = 1'b0;
    bus.mem_be    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = '0;
    bus.d_rvalid  = 1'b0;
    bus.d_rdata   = '0;
    busy          = !reset && (state_q != IDLE);

    if (d_win) begin
      bus.mem_we    = bus.d_we;
      bus.mem_be    = bus.d_be;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end else if (i_win) begin
      bus.mem_be    = '1;
      bus.mem_addr  = bus.if_addr;
    end

    if (!reset && complete) begin
      if (state_q == BUSY_IF) begin
        // A flush in the completion cycle itself still cancels the response.
        bus.if_rvalid = !drop_q && !flush;
        bus.if_rdata  = (!drop_q && !flush) ? bus.mem_rdata : '0;
      end else begin
        bus.d_rvalid  = 1'b1;
        bus.d_rdata   = store_q ? '0 : bus.mem_rdata;
      end
    end

    if (d_win) begin
      state_d = BUSY_D;
      cnt_d   = LAT_M1;
      drop_d  = 1'b0;
      store_d = bus.d_we;
    end else if (i_win) begin
      state_d = BUSY_IF;
      cnt_d   = LAT_M1;
      drop_d  = flush;
      store_d = 1'b0;
    end else if (complete) begin
      state_d = IDLE;
      drop_d  = 1'b0;
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q - 4'd1;
      if (state_q == BUSY_IF) begin
        drop_d = drop_q || flush;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic busy;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] lat_addr = '0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Read-only memory image: address captured on the grant edge, data
  // presented until the next grant.
  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h10) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk) if (bus.mem_en) lat_addr <= bus.mem_addr;
  assign bus.mem_rdata = memval(lat_addr);

  task automatic idle_inputs();
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
    flush = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    bus.if_req = 1; bus.d_req = 1; bus.d_addr = 32'h44; bus.d_be = 4'hf;
    @(negedge clk);
    tests++;
    if ({busy, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid} !== 6'b0) begin
      fails++; $display("FAIL reset_flags got %b want 000000",
        {busy, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid});
    end
    tests++;
    if ({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== 69'b0) begin
      fails++; $display("FAIL reset_membus got addr %h be %h want 0", bus.mem_addr, bus.mem_be);
    end
    @(posedge clk); #1;
    idle_inputs();
    reset = 0;
    @(negedge clk);
    tests++;
    if ({busy, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid} !== 6'b0) begin
      fails++; $display("FAIL post_reset_idle got %b want 000000",
        {busy, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid});
    end
  endtask

  task automatic test_fetch();
    @(posedge clk); #1;
    bus.if_req = 1; bus.if_addr = 32'h10;
    @(negedge clk);
    tests++;
    if ({busy, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid} !== 6'b010100) begin
      fails++; $display("FAIL fetch_T got %b want 010100",
        {busy, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid});
    end
    tests++;
    if ({bus.mem_we, bus.mem_be, bus.mem_addr} !== {1'b0, 4'hf, 32'h10}) begin
      fails++; $display("FAIL fetch_membus got we %b be %h addr %h want 0 f 10",
        bus.mem_we, bus.mem_be, bus.mem_addr);
    end
    @(posedge clk); #1;
    bus.if_req = 0; bus.if_addr = '0;
    @(negedge clk);
    tests++;
    if ({busy, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid, bus.mem_addr} !== {6'b100000, 32'h0}) begin
      fails++; $display("FAIL fetch_T1 got %b addr %h want 100000 0",
        {busy, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid}, bus.mem_addr);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({busy, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid} !== 6'b100010
        || bus.if_rdata !== 32'h0010_0093) begin
      fails++; $display("FAIL fetch_T2 got %b rdata %h want 100010 00100093",
        {busy, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid}, bus.if_rdata);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({busy, bus.if_rvalid} !== 2'b00) begin
      fails++; $display("FAIL fetch_T3 got busy %b rvalid %b want 0 0", busy, bus.if_rvalid);
    end
  endtask

  task automatic test_priority();
    @(posedge clk); #1;
    bus.if_req = 1; bus.if_addr = 32'h20;
    bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hf; bus.d_addr = 32'h10;
    @(negedge clk);
    tests++;
    if ({busy, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid, bus.mem_addr} !== {6'b001100, 32'h10}) begin
      fails++; $display("FAIL prio_T got %b addr %h want 001100 10",
        {busy, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid}, bus.mem_addr);
    end
    @(posedge clk); #1;
    bus.d_req = 0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({busy, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid} !== 6'b110101
        || bus.d_rdata !== memval(32'h10) || bus.mem_addr !== 32'h20) begin
      fails++; $display("FAIL prio_T2 got %b d_rdata %h addr %h want 110101 %h 20",
        {busy, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid},
        bus.d_rdata, bus.mem_addr, memval(32'h10));
    end
    @(posedge clk); #1;
    bus.if_req = 0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({busy, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid} !== 6'b100010
        || bus.if_rdata !== memval(32'h20)) begin
      fails++; $display("FAIL prio_T4 got %b if_rdata %h want 100010 %h",
        {busy, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid},
        bus.if_rdata, memval(32'h20));
    end
  endtask

  task automatic test_store();
    @(posedge clk); #1;
    bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'hf; bus.d_addr = 32'h10; bus.d_wdata = 32'd42;
    @(negedge clk);
    tests++;
    if ({bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr} !== {3'b111, 4'hf, 32'd42, 32'h10}) begin
      fails++; $display("FAIL store_T got gnt %b en %b we %b be %h wdata %h addr %h want 1 1 1 f 2a 10",
        bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({busy, bus.d_rvalid, bus.if_rvalid} !== 3'b110 || bus.d_rdata !== 32'h0) begin
      fails++; $display("FAIL store_ack got busy %b rvalid %b rdata %h want 1 1 0",
        busy, bus.d_rvalid, bus.d_rdata);
    end
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    bus.if_req = 1; bus.if_addr = 32'h40;
    @(negedge clk);
    tests++;
    if (bus.if_gnt !== 1'b1) begin
      fails++; $display("FAIL flush_gnt got %b want 1", bus.if_gnt);
    end
    @(posedge clk); #1;
    bus.if_req = 0; flush = 1;
    @(negedge clk);
    @(posedge clk); #1;
    flush = 0;
    bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hf; bus.d_addr = 32'h30;
    @(negedge clk);
    tests++;
    if ({bus.if_rvalid, bus.d_gnt} !== 2'b01 || bus.if_rdata !== 32'h0) begin
      fails++; $display("FAIL flush_drop got if_rvalid %b d_gnt %b if_rdata %h want 0 1 0",
        bus.if_rvalid, bus.d_gnt, bus.if_rdata);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== memval(32'h30)) begin
      fails++; $display("FAIL flush_data got rvalid %b rdata %h want 1 %h",
        bus.d_rvalid, bus.d_rdata, memval(32'h30));
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.if_req = 1; bus.if_addr = 32'h50;
    @(negedge clk);
    tests++;
    if (bus.if_gnt !== 1'b1) begin
      fails++; $display("FAIL rstmid_gnt got %b want 1", bus.if_gnt);
    end
    @(posedge clk); #1;
    reset = 1; bus.d_req = 1; bus.d_addr = 32'h60; bus.d_be = 4'hf;
    @(negedge clk);
    tests++;
    if ({busy, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid, bus.mem_addr, bus.mem_be} !== 42'b0) begin
      fails++; $display("FAIL rstmid_outputs got %b addr %h be %h want all 0",
        {busy, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid}, bus.mem_addr, bus.mem_be);
    end
    @(posedge clk); #1;
    reset = 0;
    idle_inputs();
    @(negedge clk);
    tests++;
    if ({busy, bus.if_rvalid, bus.d_rvalid} !== 3'b000) begin
      fails++; $display("FAIL rstmid_T2 got busy %b if_rvalid %b d_rvalid %b want 0 0 0",
        busy, bus.if_rvalid, bus.d_rvalid);
    end
  endtask

  task automatic test_starve();
    int k = 0;
    bit exp_if;
    @(posedge clk); #1;
    bus.if_req = 1; bus.if_addr = 32'h100;
    bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hf; bus.d_addr = 32'h200;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      tests++;
      if ((bus.if_gnt || bus.d_gnt) !== ((c % MEM_LAT) == 0)) begin
        fails++; $display("FAIL starve_cadence cycle %0d got grant %b want %b",
          c, bus.if_gnt || bus.d_gnt, (c % MEM_LAT) == 0);
      end
      if (bus.if_gnt || bus.d_gnt) begin
        exp_if = GUARD && ((k % (STARVE_MAX + 1)) == STARVE_MAX);
        tests++;
        if (bus.if_gnt !== exp_if || bus.d_gnt !== !exp_if) begin
          fails++; $display("FAIL starve_order grant %0d got if %b d %b want if %b",
            k, bus.if_gnt, bus.d_gnt, exp_if);
        end
        k++;
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int  cyc = 0;
    bit  pend = 0, p_if = 0, p_store = 0, p_drop = 0;
    int  done_t = 0, starve = 0;
    logic [31:0] p_addr = '0;
    bit  lg_d = 0, lg_i = 0;
    bit  free, comp, force_if, e_dg, e_ig, e_irv, e_drv;
    logic [31:0] e_ird, e_drd;
    logic [68:0] e_mem;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (bus.d_req && !lg_d) begin
        if ($urandom_range(9) == 0) bus.d_req = 0;
      end else begin
        bus.d_req   = ($urandom_range(2) == 0);
        bus.d_we    = $urandom_range(1);
        bus.d_be    = 4'($urandom);
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
      end
      if (bus.if_req && !lg_i) begin
        if ($urandom_range(9) == 0) bus.if_req = 0;
      end else begin
        bus.if_req  = ($urandom_range(1) == 0);
        bus.if_addr = $urandom;
      end
      flush = ($urandom_range(6) == 0);
      @(negedge clk);
      free     = !pend || cyc == done_t;
      comp     = pend && cyc == done_t;
      force_if = GUARD && starve == STARVE_MAX && bus.if_req;
      e_dg  = free && bus.d_req && !force_if;
      e_ig  = free && bus.if_req && !e_dg;
      e_irv = comp && p_if && !p_drop && !flush;
      e_ird = e_irv ? memval(p_addr) : '0;
      e_drv = comp && !p_if;
      e_drd = (e_drv && !p_store) ? memval(p_addr) : '0;
      e_mem = e_dg ? {bus.d_we, bus.d_be, bus.d_addr, bus.d_wdata}
            : e_ig ? {1'b0, 4'hf, bus.if_addr, 32'h0} : 69'h0;
      tests++;
      if ({busy, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid}
          !== {pend, e_ig, e_dg, e_dg || e_ig, e_irv, e_drv}) begin
        fails++; $display("FAIL rand_flags cycle %0d got %b want %b", cyc,
          {busy, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid},
          {pend, e_ig, e_dg, e_dg || e_ig, e_irv, e_drv});
      end
      tests++;
      if ({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== e_mem) begin
        fails++; $display("FAIL rand_membus cycle %0d got %h want %h", cyc,
          {bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata}, e_mem);
      end
      tests++;
      if (bus.if_rdata !== e_ird || bus.d_rdata !== e_drd) begin
        fails++; $display("FAIL rand_rdata cycle %0d got if %h d %h want if %h d %h", cyc,
          bus.if_rdata, bus.d_rdata, e_ird, e_drd);
      end
      if (e_dg || e_ig) begin
        pend = 1; done_t = cyc + MEM_LAT; p_if = e_ig;
        p_store = e_dg && bus.d_we; p_drop = e_ig && flush;
        p_addr = e_dg ? bus.d_addr : bus.if_addr;
      end else if (comp) begin
        pend = 0;
      end else if (pend && p_if) begin
        p_drop = p_drop || flush;
      end
      if (e_ig || !bus.if_req) starve = 0;
      else if (e_dg) starve++;
      lg_d = e_dg; lg_i = e_ig;
      cyc++;
    end
    @(posedge clk); #1;
    idle_inputs();
    repeat (MEM_LAT + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_flush();
    test_reset_mid();
    test_starve();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
